// File: rtl/vc_arbiter_router.sv
// vc_arbiter_router
// Strict-priority arbiter sitting behind the VC0/VC1 virtual-channel FIFOs.
// It pops VC0 ahead of VC1, captures the popped word one cycle later and
// routes it to destination FIFO D0 or D1 according to word[DEST_BIT]. Pops
// stop while either destination FIFO reports almost-full.
//
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous, active-low reset
//   empty_fifo_VC0/VC1   VC FIFO empty flags
//   data_out_VC0/VC1     VC FIFO read data, valid the cycle after a pop
//   almost_full_fifo_D0/D1  destination backpressure
//   pop_VC0_fifo/VC1     combinational read strobes to the VC FIFOs
//   push_D0/D1           registered write strobes to the destination FIFOs
//   data_D0/D1           registered write data to the destination FIFOs
//   state                FSM state (IDLE=0, ACTIVE=1, PAUSE=2)
//   cnt_D0/D1            words pushed to each destination since reset (wrapping)
module vc_arbiter_router #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty_fifo_VC0,
    input  logic                  empty_fifo_VC1,
    input  logic [DATA_WIDTH-1:0] data_out_VC0,
    input  logic [DATA_WIDTH-1:0] data_out_VC1,
    input  logic                  almost_full_fifo_D0,
    input  logic                  almost_full_fifo_D1,
    output logic                  pop_VC0_fifo,
    output logic                  pop_VC1_fifo,
    output logic                  push_D0,
    output logic                  push_D1,
    output logic [DATA_WIDTH-1:0] data_D0,
    output logic [DATA_WIDTH-1:0] data_D1,
    output logic [1:0]            state,
    output logic [CNT_WIDTH-1:0]  cnt_D0,
    output logic [CNT_WIDTH-1:0]  cnt_D1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q;
    logic                    pause;
    logic                    vc_has_data;
    logic                    vld_p0;
    logic                    src_vc1_p0;
    logic [DATA_WIDTH-1:0]   word_p1;
    logic                    dest_d1_p1;

    // The destination of a word is unknown until it is read, so any
    // almost-full destination stalls both VCs.
    assign pause       = almost_full_fifo_D0 | almost_full_fifo_D1;
    assign vc_has_data = ~empty_fifo_VC0 | ~empty_fifo_VC1;

    assign pop_VC0_fifo = (state_q == ACTIVE) & ~pause & ~empty_fifo_VC0;
    assign pop_VC1_fifo = (state_q == ACTIVE) & ~pause & empty_fifo_VC0 & ~empty_fifo_VC1;

    assign state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pause)            state_q <= PAUSE;
                    else if (vc_has_data) state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (pause)             state_q <= PAUSE;
                    else if (!vc_has_data) state_q <= IDLE;
                end
                PAUSE: begin
                    if (!pause) state_q <= vc_has_data ? ACTIVE : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ---- stage p0: pop issued, remember that a word is in flight and its source
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0     <= 1'b0;
            src_vc1_p0 <= 1'b0;
        end else begin
            vld_p0     <= pop_VC0_fifo | pop_VC1_fifo;
            src_vc1_p0 <= pop_VC1_fifo;
        end
    end

    // ---- stage p1: FIFO read data is now valid; select it and decode destination
    assign word_p1    = src_vc1_p0 ? data_out_VC1 : data_out_VC0;
    assign dest_d1_p1 = word_p1[DEST_BIT];

    // ---- stage p2: registered push to the chosen destination. In-flight words
    // are delivered regardless of pause or FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_D0 <= 1'b0;
            push_D1 <= 1'b0;
            data_D0 <= '0;
            data_D1 <= '0;
        end else begin
            push_D0 <= vld_p0 & ~dest_d1_p1;
            push_D1 <= vld_p0 & dest_d1_p1;
            if (vld_p0 && !dest_d1_p1) data_D0 <= word_p1;
            if (vld_p0 && dest_d1_p1)  data_D1 <= word_p1;
        end
    end

    // Counters follow the registered push strobes and wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_D0 <= '0;
            cnt_D1 <= '0;
        end else begin
            if (push_D0) cnt_D0 <= cnt_D0 + CNT_ONE;
            if (push_D1) cnt_D1 <= cnt_D1 + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_vc_arbiter_router.sv
module tb_vc_arbiter_router;

    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          empty_fifo_VC0, empty_fifo_VC1;
    logic [DW-1:0] data_out_VC0, data_out_VC1;
    logic          almost_full_fifo_D0, almost_full_fifo_D1;
    logic          pop_VC0_fifo, pop_VC1_fifo;
    logic          push_D0, push_D1;
    logic [DW-1:0] data_D0, data_D1;
    logic [1:0]    state;
    logic [CW-1:0] cnt_D0, cnt_D1;

    int n_checks = 0;
    int n_fail   = 0;

    // Simple VC FIFO models: read data registered on pop, empty follows the pointers.
    logic [DW-1:0] mem0 [0:1023];
    logic [DW-1:0] mem1 [0:1023];
    int rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;

    assign empty_fifo_VC0 = (rd0 == wr0);
    assign empty_fifo_VC1 = (rd1 == wr1);

    initial begin
        data_out_VC0 = '0;
        data_out_VC1 = '0;
    end

    always @(posedge clk) begin
        if (pop_VC0_fifo) begin
            data_out_VC0 <= mem0[rd0];
            rd0 <= rd0 + 1;
        end
        if (pop_VC1_fifo) begin
            data_out_VC1 <= mem1[rd1];
            rd1 <= rd1 + 1;
        end
    end

    always #5 clk = ~clk;

    vc_arbiter_router #(.DATA_WIDTH(DW), .DEST_BIT(4), .CNT_WIDTH(CW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .empty_fifo_VC0      (empty_fifo_VC0),
        .empty_fifo_VC1      (empty_fifo_VC1),
        .data_out_VC0        (data_out_VC0),
        .data_out_VC1        (data_out_VC1),
        .almost_full_fifo_D0 (almost_full_fifo_D0),
        .almost_full_fifo_D1 (almost_full_fifo_D1),
        .pop_VC0_fifo        (pop_VC0_fifo),
        .pop_VC1_fifo        (pop_VC1_fifo),
        .push_D0             (push_D0),
        .push_D1             (push_D1),
        .data_D0             (data_D0),
        .data_D1             (data_D1),
        .state               (state),
        .cnt_D0              (cnt_D0),
        .cnt_D1              (cnt_D1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vc0(input logic [DW-1:0] w);
        mem0[wr0] = w;
        wr0 = wr0 + 1;
    endtask

    task automatic load_vc1(input logic [DW-1:0] w);
        mem1[wr1] = w;
        wr1 = wr1 + 1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        almost_full_fifo_D0 = 1'b0;
        almost_full_fifo_D1 = 1'b0;
        load_vc0(6'h12);
        load_vc0(6'h25);
        load_vc1(6'h31);
        step();
        step();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++; if ({pop_VC0_fifo, pop_VC1_fifo} !== 2'b00) begin n_fail++; $display("FAIL reset_pops: got %b expected 00", {pop_VC0_fifo, pop_VC1_fifo}); end
        n_checks++; if ({push_D0, push_D1} !== 2'b00) begin n_fail++; $display("FAIL reset_push: got %b expected 00", {push_D0, push_D1}); end
        n_checks++; if ({data_D0, data_D1} !== 12'h000) begin n_fail++; $display("FAIL reset_data: got %h expected 000", {data_D0, data_D1}); end
        n_checks++; if ({cnt_D0, cnt_D1} !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0000", {cnt_D0, cnt_D1}); end
    endtask

    task automatic test_priority();
        reset = 1'b1;
        step();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL prio_state_active: got %0d expected 1", state); end
        n_checks++; if ({pop_VC0_fifo, pop_VC1_fifo} !== 2'b10) begin n_fail++; $display("FAIL prio_pop1: got %b expected 10", {pop_VC0_fifo, pop_VC1_fifo}); end
        step();
        n_checks++; if ({pop_VC0_fifo, pop_VC1_fifo} !== 2'b10) begin n_fail++; $display("FAIL prio_pop2: got %b expected 10", {pop_VC0_fifo, pop_VC1_fifo}); end
        n_checks++; if ({push_D0, push_D1} !== 2'b00) begin n_fail++; $display("FAIL prio_no_push_yet: got %b expected 00", {push_D0, push_D1}); end
        step();
        n_checks++; if ({push_D0, push_D1} !== 2'b01) begin n_fail++; $display("FAIL prio_push_12: got %b expected 01", {push_D0, push_D1}); end
        n_checks++; if (data_D1 !== 6'h12) begin n_fail++; $display("FAIL prio_data_12: got %h expected 12", data_D1); end
        n_checks++; if ({pop_VC0_fifo, pop_VC1_fifo} !== 2'b01) begin n_fail++; $display("FAIL prio_pop_vc1: got %b expected 01", {pop_VC0_fifo, pop_VC1_fifo}); end
        step();
        n_checks++; if ({push_D0, push_D1} !== 2'b10) begin n_fail++; $display("FAIL prio_push_25: got %b expected 10", {push_D0, push_D1}); end
        n_checks++; if (data_D0 !== 6'h25) begin n_fail++; $display("FAIL prio_data_25: got %h expected 25", data_D0); end
        n_checks++; if ({pop_VC0_fifo, pop_VC1_fifo} !== 2'b00) begin n_fail++; $display("FAIL prio_pops_done: got %b expected 00", {pop_VC0_fifo, pop_VC1_fifo}); end
        step();
        n_checks++; if ({push_D0, push_D1} !== 2'b01) begin n_fail++; $display("FAIL prio_push_31: got %b expected 01", {push_D0, push_D1}); end
        n_checks++; if (data_D1 !== 6'h31) begin n_fail++; $display("FAIL prio_data_31: got %h expected 31", data_D1); end
        n_checks++; if (data_D0 !== 6'h25) begin n_fail++; $display("FAIL prio_d0_hold: got %h expected 25", data_D0); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL prio_state_idle: got %0d expected 0", state); end
        step();
        n_checks++; if ({push_D0, push_D1} !== 2'b00) begin n_fail++; $display("FAIL prio_push_clear: got %b expected 00", {push_D0, push_D1}); end
        n_checks++; if (cnt_D0 !== 8'd1) begin n_fail++; $display("FAIL prio_cnt_d0: got %0d expected 1", cnt_D0); end
        n_checks++; if (cnt_D1 !== 8'd2) begin n_fail++; $display("FAIL prio_cnt_d1: got %0d expected 2", cnt_D1); end
    endtask

    task automatic test_backpressure();
        load_vc0(6'h05);
        load_vc0(6'h07);
        step();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL bp_state_active: got %0d expected 1", state); end
        n_checks++; if (pop_VC0_fifo !== 1'b1) begin n_fail++; $display("FAIL bp_pop_first: got %b expected 1", pop_VC0_fifo); end
        step();
        almost_full_fifo_D0 = 1'b1;
        #1;
        n_checks++; if (pop_VC0_fifo !== 1'b0) begin n_fail++; $display("FAIL bp_pop_gated: got %b expected 0", pop_VC0_fifo); end
        step();
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL bp_state_pause: got %0d expected 2", state); end
        n_checks++; if (push_D0 !== 1'b1) begin n_fail++; $display("FAIL bp_inflight_push: got %b expected 1", push_D0); end
        n_checks++; if (data_D0 !== 6'h05) begin n_fail++; $display("FAIL bp_inflight_data: got %h expected 05", data_D0); end
        step();
        n_checks++; if ({pop_VC0_fifo, push_D0, state} !== 4'b0010) begin n_fail++; $display("FAIL bp_hold: got %b expected 0010", {pop_VC0_fifo, push_D0, state}); end
        almost_full_fifo_D0 = 1'b0;
        #1;
        n_checks++; if (pop_VC0_fifo !== 1'b0) begin n_fail++; $display("FAIL bp_no_pop_in_pause: got %b expected 0", pop_VC0_fifo); end
        step();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL bp_resume_state: got %0d expected 1", state); end
        n_checks++; if (pop_VC0_fifo !== 1'b1) begin n_fail++; $display("FAIL bp_resume_pop: got %b expected 1", pop_VC0_fifo); end
        step();
        n_checks++; if ({pop_VC0_fifo, push_D0} !== 2'b00) begin n_fail++; $display("FAIL bp_after_pop: got %b expected 00", {pop_VC0_fifo, push_D0}); end
        step();
        n_checks++; if ({push_D0, data_D0} !== {1'b1, 6'h07}) begin n_fail++; $display("FAIL bp_second_push: got %h expected 47", {push_D0, data_D0}); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL bp_state_idle: got %0d expected 0", state); end
        step();
        n_checks++; if (cnt_D0 !== 8'd3) begin n_fail++; $display("FAIL bp_cnt_d0: got %0d expected 3", cnt_D0); end
    endtask

    task automatic test_drain();
        load_vc1(6'h11);
        step();
        n_checks++; if ({pop_VC0_fifo, pop_VC1_fifo} !== 2'b01) begin n_fail++; $display("FAIL drain_pop_vc1: got %b expected 01", {pop_VC0_fifo, pop_VC1_fifo}); end
        step();
        n_checks++; if ({pop_VC1_fifo, state} !== 3'b001) begin n_fail++; $display("FAIL drain_empty_active: got %b expected 001", {pop_VC1_fifo, state}); end
        step();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL drain_state_idle: got %0d expected 0", state); end
        n_checks++; if ({push_D1, data_D1} !== {1'b1, 6'h11}) begin n_fail++; $display("FAIL drain_push: got %h expected 51", {push_D1, data_D1}); end
        step();
        n_checks++; if ({push_D0, push_D1} !== 2'b00) begin n_fail++; $display("FAIL drain_push_clear: got %b expected 00", {push_D0, push_D1}); end
        n_checks++; if (cnt_D1 !== 8'd3) begin n_fail++; $display("FAIL drain_cnt_d1: got %0d expected 3", cnt_D1); end
    endtask

    task automatic test_midflight_reset();
        load_vc0(6'h20);
        step();
        n_checks++; if (pop_VC0_fifo !== 1'b1) begin n_fail++; $display("FAIL mfr_pop: got %b expected 1", pop_VC0_fifo); end
        step();
        reset = 1'b0;
        #1;
        n_checks++; if ({state, push_D0, push_D1, cnt_D0, cnt_D1} !== 20'h0) begin n_fail++; $display("FAIL mfr_async_clear: got %h expected 0", {state, push_D0, push_D1, cnt_D0, cnt_D1}); end
        step();
        reset = 1'b1;
        step();
        step();
        n_checks++; if ({push_D0, push_D1} !== 2'b00) begin n_fail++; $display("FAIL mfr_no_push: got %b expected 00", {push_D0, push_D1}); end
        n_checks++; if ({cnt_D0, cnt_D1} !== 16'h0000) begin n_fail++; $display("FAIL mfr_cnt: got %h expected 0000", {cnt_D0, cnt_D1}); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL mfr_state: got %0d expected 0", state); end
    endtask

    task automatic test_counter_wrap();
        logic [7:0] v;
        int pushes0;
        int pushes1;
        pushes0 = 0;
        pushes1 = 0;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i) & 8'h2F;
            load_vc0(v[DW-1:0]);
        end
        for (int c = 0; c < 264; c++) begin
            step();
            if (push_D0) pushes0++;
            if (push_D1) pushes1++;
        end
        n_checks++; if (pushes0 !== 256) begin n_fail++; $display("FAIL wrap_push_count_d0: got %0d expected 256", pushes0); end
        n_checks++; if (pushes1 !== 0) begin n_fail++; $display("FAIL wrap_push_count_d1: got %0d expected 0", pushes1); end
        n_checks++; if (cnt_D0 !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt_d0: got %0d expected 0", cnt_D0); end
        n_checks++; if (cnt_D1 !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt_d1: got %0d expected 0", cnt_D1); end
        n_checks++; if (data_D0 !== 6'h2F) begin n_fail++; $display("FAIL wrap_last_data: got %h expected 2f", data_D0); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL wrap_state: got %0d expected 0", state); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_backpressure();
        test_drain();
        test_midflight_reset();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_arbiter_router.md
Name: vc_arbiter_router

Overview:
- Stage directly downstream of the VC0/VC1 virtual-channel FIFOs in the PCI transmission path.
- Strict-priority arbiter: drains VC0 ahead of VC1 by issuing `pop_VC0_fifo`/`pop_VC1_fifo`, captures the popped word, and routes it to destination FIFO D0 or D1 according to a destination bit in the word.
- Stops issuing pops while either destination FIFO reports almost-full (backpressure).

Parameters:
- DATA_WIDTH, 6, word width; must match the VC FIFO `data_out` width.
- DEST_BIT, 4, bit index in the word selecting the destination (0 -> D0, 1 -> D1).
- CNT_WIDTH, 8, width of the per-destination forwarded-word counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- empty_fifo_VC0  in  1  VC0 FIFO empty flag (registered in the FIFO).
- empty_fifo_VC1  in  1  VC1 FIFO empty flag.
- data_out_VC0  in  DATA_WIDTH  VC0 read data; valid the cycle after a pop.
- data_out_VC1  in  DATA_WIDTH  VC1 read data; valid the cycle after a pop.
- almost_full_fifo_D0  in  1  D0 FIFO almost-full (backpressure).
- almost_full_fifo_D1  in  1  D1 FIFO almost-full (backpressure).
- pop_VC0_fifo  out  1  read strobe to VC0 FIFO.
- pop_VC1_fifo  out  1  read strobe to VC1 FIFO.
- push_D0  out  1  write strobe to D0 FIFO (registered).
- push_D1  out  1  write strobe to D1 FIFO (registered).
- data_D0  out  DATA_WIDTH  write data to D0 (registered).
- data_D1  out  DATA_WIDTH  write data to D1 (registered).
- state  out  2  FSM state: IDLE=0, ACTIVE=1, PAUSE=2.
- cnt_D0  out  CNT_WIDTH  words pushed to D0 since reset.
- cnt_D1  out  CNT_WIDTH  words pushed to D1 since reset.

Behaviour:

Reset and asynchrony:
- While reset=0 (asynchronous): state=IDLE; the in-flight flag and all registered outputs clear to 0. This covers push_D0/D1, data_D0/D1 and cnt_D0/D1.
- pop_VC0/1 are combinational and are gated low in IDLE, so they also read 0.

Backpressure and pop rules:
- pause = almost_full_fifo_D0 | almost_full_fifo_D1. The destination is unknown before the pop, so backpressure is conservative.
- pop_VC0_fifo = (state==ACTIVE) & ~pause & ~empty_fifo_VC0.
- pop_VC1_fifo = (state==ACTIVE) & ~pause & empty_fifo_VC0 & ~empty_fifo_VC1.
- The two pops are never high in the same cycle; VC0 has strict priority.

FSM (registered), evaluated each edge:
- IDLE -> PAUSE if pause; else -> ACTIVE if either VC FIFO is non-empty; else stay.
- ACTIVE -> PAUSE if pause; else -> IDLE if both VC FIFOs are empty; else stay.
- PAUSE -> stays while pause; else -> ACTIVE if data is present, else -> IDLE.
- First pop after leaving IDLE/PAUSE occurs one cycle after the transition, because pops require ACTIVE.

Datapath pipeline:
- Pop in cycle N sets in-flight valid and records the source VC.
- In cycle N+1, the word is sampled from the selected `data_out_VCx`.
- At the end of N+1 the word is registered into data_Dx, selected by `word[DEST_BIT]`, and the matching push_Dx is set for cycle N+2.
- Latency pop -> push: 2 cycles. Sustained throughput: 1 word/cycle.
- push_D0 and push_D1 are mutually exclusive; both are 0 in cycles with no delivery.
- The unselected data_Dx holds its previous value.

In-flight handling:
- A word already popped is always delivered, even if pause rises in N+1. The D FIFO almost-full threshold must leave at least 2 free entries.
- The FSM leaving ACTIVE does not cancel the in-flight delivery.

Counters:
- cnt_Dx increments by 1 on every cycle in which push_Dx is registered high.
- Counters wrap modulo 2^CNT_WIDTH.

Boundary cases:
- Empty-flag update: a pop of the last VC0 word at N sees empty_fifo_VC0=1 at N+1, so the VC1 pop is issued at N+1 if VC1 is non-empty.
- Both VC FIFOs empty while ACTIVE: no pops.
- Reset mid-operation: the in-flight word is discarded and no push follows deassertion.

Test Plan:
- Reset: hold reset=0 with VC FIFOs non-empty -> all outputs 0, state=0; release -> state=1 next edge, pop_VC0 one cycle later.
- Priority: VC0 holds words 0x12, 0x25; VC1 holds 0x31 -> pops VC0, VC0, VC1 in consecutive cycles.
  - 0x12 (bit4=1) -> push_D1, data_D1=0x12.
  - 0x25 (bit4=0) -> push_D0, data_D0=0x25.
  - 0x31 (bit4=1) -> push_D1, data_D1=0x31.
  - Each push occurs 2 cycles after its pop; final cnt_D0=1, cnt_D1=2.
- Backpressure: raise almost_full_fifo_D0 in the cycle after a pop -> that word is still pushed, state=2, no pops while high; drop it -> ACTIVE next edge, pops resume one cycle later.
- Drain to idle: last VC1 word popped with VC0 empty -> state returns to 0 once both are empty; push_Dx = 0 after final delivery.
- Counter wrap: push 256 words with bit4=0 -> cnt_D0 wraps to 0, cnt_D1 stays 0.
- Mid-flight reset: assert reset=0 in the cycle after a pop -> no push on release, counters 0.
